// File: rtl/wb_sram_arbiter_if.sv
// Signal bundle between the two Wishbone masters, the arbiter and the SRAM controller slave port.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface wb_sram_arbiter_if;
  logic        m0_cyc_i;
  logic        m0_stb_i;
  logic        m0_we_i;
  logic [31:0] m0_adr_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_dat_i;
  logic [31:0] m0_dat_o;
  logic        m0_ack_o;
  logic        m0_err_o;

  logic        m1_cyc_i;
  logic        m1_stb_i;
  logic        m1_we_i;
  logic [31:0] m1_adr_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_dat_i;
  logic [31:0] m1_dat_o;
  logic        m1_ack_o;
  logic        m1_err_o;

  logic        s_cyc_o;
  logic        s_stb_o;
  logic        s_we_o;
  logic [31:0] s_adr_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i;

  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_sel_i, m0_dat_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_sel_i, m1_dat_i,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
    input  s_dat_i, s_ack_i
  );

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_sel_i, m0_dat_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_sel_i, m1_dat_i,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
    output s_dat_i, s_ack_i
  );
endinterface

// File: rtl/wb_sram_arbiter.sv
// Two-master Wishbone arbiter for the SRAM controller: round-robin on ties, latched slave request,
// one idle cycle after every completion, and a watchdog that errors a transaction the slave never acks.
module wb_sram_arbiter #(
  parameter int unsigned timeout_cycles = 255
) (
  input logic               clk,
  input logic               reset,
  wb_sram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StBusy0, StBusy1, StHold} state_e;

  localparam bit          WdEnable = (timeout_cycles != 0);
  localparam logic [15:0] WdLast   = 16'(timeout_cycles - 1);

  state_e      state_q;
  logic        lg_q;
  logic [15:0] wd_q;
  logic        stb_q;
  logic        we_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;

  logic req0, req1, grant1, busy0, busy1, wd_expire;

  always_comb begin
    req0      = bus.m0_cyc_i & bus.m0_stb_i;
    req1      = bus.m1_cyc_i & bus.m1_stb_i;
    // On a tie the master that did not win last time gets the bus.
    grant1    = req1 & (~req0 | ~lg_q);
    busy0     = (state_q == StBusy0);
    busy1     = (state_q == StBusy1);
    wd_expire = WdEnable && (wd_q == WdLast);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      lg_q    <= 1'b1;
      wd_q    <= '0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req0 | req1) begin
            state_q <= grant1 ? StBusy1 : StBusy0;
            lg_q    <= grant1;
            wd_q    <= '0;
            stb_q   <= 1'b1;
            we_q    <= grant1 ? bus.m1_we_i  : bus.m0_we_i;
            adr_q   <= grant1 ? bus.m1_adr_i : bus.m0_adr_i;
            dat_q   <= grant1 ? bus.m1_dat_i : bus.m0_dat_i;
            sel_q   <= grant1 ? bus.m1_sel_i : bus.m0_sel_i;
          end
        end
        StBusy0, StBusy1: begin
          // Ack has priority over an expiring watchdog in the same cycle.
          if (bus.s_ack_i || wd_expire) begin
            state_q <= StHold;
            stb_q   <= 1'b0;
          end else begin
            wd_q <= wd_q + 16'd1;
          end
        end
        StHold: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.s_cyc_o  = stb_q;
  assign bus.s_stb_o  = stb_q;
  assign bus.s_we_o   = we_q;
  assign bus.s_adr_o  = adr_q;
  assign bus.s_dat_o  = dat_q;
  assign bus.s_sel_o  = sel_q;

  // A master that dropped cyc mid-transaction gets neither ack nor err.
  assign bus.m0_ack_o = busy0 & bus.s_ack_i & bus.m0_cyc_i;
  assign bus.m1_ack_o = busy1 & bus.s_ack_i & bus.m1_cyc_i;
  assign bus.m0_err_o = busy0 & ~bus.s_ack_i & wd_expire & bus.m0_cyc_i;
  assign bus.m1_err_o = busy1 & ~bus.s_ack_i & wd_expire & bus.m1_cyc_i;

  assign bus.m0_dat_o = bus.s_dat_i;
  assign bus.m1_dat_o = bus.s_dat_i;

endmodule
